// File: rtl/wb_pkg.sv
// Shared widths and the queue entry type for the register-file writeback path.
package wb_pkg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the writeback queue for one decode operand index.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTRW = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] ent,
  input  logic [DEPTH-1:0]      vld,
  input  logic [PTRW-1:0]       rd_ptr,
  input  logic [AW-1:0]         idx,
  output logic                  hit,
  output logic [DW-1:0]         fwd
);
  logic [PTRW-1:0] slot;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit  = 1'b0;
    fwd  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTRW'(k);
      if (vld[slot] && ent[slot].rd == idx && idx != REG_ZERO) begin
        hit = 1'b1;
        fwd = ent[slot].data;
      end
    end
  end
endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue: accepts Mem/Ex results, drains one per cycle to the
// register file write port, and forwards pending data to decode.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Mem_valid,
  input  logic [AW-1:0]            Mem_rd,
  input  logic [DW-1:0]            Mem_data,
  output logic                     Mem_ready,
  input  logic                     Ex_valid,
  input  logic [AW-1:0]            Ex_rd,
  input  logic [DW-1:0]            Ex_data,
  output logic                     Ex_ready,
  input  logic                     Wb_en,
  output logic [DW-1:0]            PW,
  output logic [AW-1:0]            RW,
  output logic                     LE,
  input  logic [AW-1:0]            Chk_ra,
  input  logic [AW-1:0]            Chk_rb,
  output logic                     Hit_a,
  output logic                     Hit_b,
  output logic [DW-1:0]            Fwd_a,
  output logic [DW-1:0]            Fwd_b,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  wb_entry_t [DEPTH-1:0] q;
  logic [PTRW-1:0]       rd_ptr, wr_ptr, ex_slot, off;
  logic [CW-1:0]         cnt;
  logic [DEPTH-1:0]      vld;
  logic                  mem_nz, ex_nz, mem_push, ex_push, pop;
  logic [1:0][AW-1:0]    chk;
  logic [1:0]            hit_raw;
  logic [1:0][DW-1:0]    fwd_raw;

  assign mem_nz = Mem_rd != REG_ZERO;
  assign ex_nz  = Ex_rd != REG_ZERO;

  // Credit comes from the registered count only; a same-cycle pop is not counted.
  assign Mem_ready = Rst_n && (cnt < CW'(DEPTH));
  assign Ex_ready  = Rst_n && ((cnt + CW'(Mem_valid & mem_nz)) < CW'(DEPTH));

  assign mem_push = Mem_valid & Mem_ready & mem_nz;
  assign ex_push  = Ex_valid & Ex_ready & ex_nz;
  assign ex_slot  = wr_ptr + PTRW'(mem_push);

  assign Empty = cnt == '0;
  assign Full  = cnt == CW'(DEPTH);
  assign Count = cnt;
  assign pop   = Rst_n & Wb_en & ~Empty;
  assign LE    = pop;
  assign PW    = q[rd_ptr].data;
  assign RW    = q[rd_ptr].rd;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTRW'(pop);
      wr_ptr <= wr_ptr + PTRW'(mem_push) + PTRW'(ex_push);
      cnt    <= cnt + CW'(mem_push) + CW'(ex_push) - CW'(pop);
    end
  end

  // Mem is the older instruction, so it takes the lower slot.
  always_ff @(posedge Clk) begin
    if (mem_push) q[wr_ptr]  <= '{rd: Mem_rd, data: Mem_data};
    if (ex_push)  q[ex_slot] <= '{rd: Ex_rd, data: Ex_data};
  end

  always_comb begin
    vld = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PTRW'(i) - rd_ptr;
      vld[i] = CW'(off) < cnt;
    end
  end

  assign chk = {Chk_rb, Chk_ra};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
      .ent    (q),
      .vld    (vld),
      .rd_ptr (rd_ptr),
      .idx    (chk[g]),
      .hit    (hit_raw[g]),
      .fwd    (fwd_raw[g])
    );
  end

  assign Hit_a = Rst_n & hit_raw[0];
  assign Hit_b = Rst_n & hit_raw[1];
  assign Fwd_a = Hit_a ? fwd_raw[0] : '0;
  assign Fwd_b = Hit_b ? fwd_raw[1] : '0;
endmodule
